pc_sequencer: RTL

- Fetch-side sequencer for the single-cycle MIPS datapath, sitting directly upstream of the instruction decoder.
- Holds the program counter and the status-flag register (Z, N, V).
- Each cycle it selects the next PC from the decoder's branch/jump strobes, the ALU outcome and the registered flags.
- Supplies the decoder with its `ne` input, and the writeback mux with the link address and link selector.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/status_reg.sv | 34 +++
 rtl/pc_sequencer.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, encodings and helpers for the single-cycle MIPS fetch path.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BMV   = 6'b010100;
    localparam logic [5:0] OP_BALN  = 6'b011011;
    localparam logic [5:0] OP_JALPC = 6'b011111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BNEAL = 6'b101101;

    localparam logic [5:0] FN_BALRN = 6'b011000;

    typedef enum logic [1:0] {
        LINK_NONE = 2'd0,
        LINK_RA   = 2'd1,
        LINK_RD   = 2'd2
    } link_sel_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/status_reg.sv
// status_reg: Z/N/V flag register, updated only by an advancing R-type that is not balrn.
module status_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_en,
    input  logic        rformat,
    input  logic        balrne,
    input  logic [31:0] alu_result,
    input  logic        alu_ovf,
    output logic        stat_z,
    output logic        stat_n,
    output logic        stat_v
);

    logic upd;

    // balrn is R-format but its ALU result is not a flag-producing operation.
    assign upd = pc_en && rformat && !balrne;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_z <= 1'b0;
            stat_n <= 1'b0;
            stat_v <= 1'b0;
        end else if (upd) begin
            stat_z <= (alu_result == 32'd0);
            stat_n <= alu_result[31];
            stat_v <= alu_ovf;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, next-PC selection and link control for the fetch side.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic [31:0]       instr,
    input  logic              branch,
    input  logic              bmve,
    input  logic              balne,
    input  logic              jalpce,
    input  logic              bleze,
    input  logic              bneale,
    input  logic              balrne,
    input  logic              rformat,
    input  logic [31:0]       alu_result,
    input  logic              alu_ovf,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              ne,
    output logic [31:0]       link_addr,
    output logic [1:0]        link_sel,
    output logic              stat_z,
    output logic              stat_n,
    output logic              stat_v
);

    logic [31:0]       pc4;
    logic [31:0]       boff;
    logic [31:0]       jtgt;
    logic [31:0]       btgt;
    logic [31:0]       next_pc;
    link_sel_e         lsel;

    status_reg u_status (
        .clk        (clk),
        .reset      (reset),
        .pc_en      (pc_en),
        .rformat    (rformat),
        .balrne     (balrne),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .stat_z     (stat_z),
        .stat_n     (stat_n),
        .stat_v     (stat_v)
    );

    assign pc4       = 32'(pc) + 32'd4;
    assign pc_plus4  = ADDR_W'(pc4);
    assign link_addr = pc4;
    assign ne        = (rs_data != rt_data);
    assign boff      = branch_offset(instr[15:0]);
    assign jtgt      = {pc4[31:28], instr[25:0], 2'b00};
    assign btgt      = pc4 + boff;
    assign link_sel  = lsel;

    // Flags used here are always the registered ones from an earlier R-type.
    always_comb begin
        next_pc = pc4;
        next_pc = (balrne && stat_n)                 ? rs_data   :
                  jalpce                             ? jtgt      :
                  (balne && stat_n)                  ? jtgt      :
                  (bmve && stat_n)                   ? mem_rdata :
                  (bneale && ne)                     ? btgt      :
                  (bleze && (stat_z || stat_n))      ? btgt      :
                  (branch && (alu_result == 32'd0))  ? btgt      : pc4;
        lsel    = (balrne && stat_n)                              ? LINK_RD :
                  (jalpce || (balne && stat_n) || (bneale && ne)) ? LINK_RA : LINK_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc <= ADDR_W'(RESET_PC);
        else if (pc_en)
            pc <= ADDR_W'(next_pc);
    end

endmodule
